// File: rtl/ov7670_sccb_init.sv
// ----------------------------------------------------------------------------
// ov7670_sccb_init
//
// Brings up an OV7670 camera after reset by writing a fixed 17-entry register
// table over SCCB (write-only, device address 0x42). The first entry is the
// COM7 soft reset, so a longer settle delay follows it. Every other write is
// followed by a short gap. Once the last entry has been written the bus idles
// high and init_done stays high until the next reset.
//
// Ports
//   clk        in   1  system clock (100 MHz nominal)
//   rst        in   1  synchronous active-high reset; restarts the whole table
//   sioc       out  1  SCCB clock, idles high, registered
//   siod       out  1  SCCB data, push-pull, idles high, registered
//   init_done  out  1  high once all 17 writes have completed
// ----------------------------------------------------------------------------
module ov7670_sccb_init #(
    parameter int INIT_DELAY  = 100000,
    parameter int RESET_DELAY = 100000,
    parameter int GAP_DELAY   = 5000,
    parameter int QTR         = 250
) (
    input  logic clk,
    input  logic rst,
    output logic sioc,
    output logic siod,
    output logic init_done
);

    localparam int MAX_A = (INIT_DELAY > RESET_DELAY) ? INIT_DELAY : RESET_DELAY;
    localparam int MAX_B = (MAX_A > GAP_DELAY) ? MAX_A : GAP_DELAY;
    localparam int MAX_C = (MAX_B > QTR) ? MAX_B : QTR;
    localparam int CW    = $clog2(MAX_C + 1);

    typedef enum logic [2:0] {
        WAIT_INIT,
        START,
        BITS,
        STOP,
        DELAY,
        DONE
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [1:0]    qtr, qtr_n;
    logic [4:0]    bit_idx, bit_n;
    logic [4:0]    idx, idx_n;
    logic          sioc_n, siod_n, done_n;

    logic [15:0]   entry;
    logic [26:0]   frame;
    logic [4:0]    bit_pos;
    logic          qtr_last;
    logic [CW-1:0] delay_last;

    // Register table, looked up with the next index so the registered siod
    // lines up with the registered state.
    always_comb begin
        entry = 16'hFFFF;
        case (idx_n)
            5'd0:  entry = 16'h1280;
            5'd1:  entry = 16'h1214;
            5'd2:  entry = 16'h40D0;
            5'd3:  entry = 16'h8C00;
            5'd4:  entry = 16'h1101;
            5'd5:  entry = 16'h0C00;
            5'd6:  entry = 16'h3E00;
            5'd7:  entry = 16'h0400;
            5'd8:  entry = 16'h3A04;
            5'd9:  entry = 16'h13E7;
            5'd10: entry = 16'h1448;
            5'd11: entry = 16'h1716;
            5'd12: entry = 16'h1804;
            5'd13: entry = 16'h3224;
            5'd14: entry = 16'h1902;
            5'd15: entry = 16'h1A7A;
            5'd16: entry = 16'h030A;
            default: entry = 16'hFFFF;
        endcase
    end

    // 27-bit SCCB frame; the don't-care (ack) slots are driven high.
    assign frame      = {8'h42, 1'b1, entry[15:8], 1'b1, entry[7:0], 1'b1};
    assign bit_pos    = 5'd26 - bit_n;
    assign qtr_last   = (cnt == CW'(QTR - 1));
    assign delay_last = (idx == 5'd0) ? CW'(RESET_DELAY - 1) : CW'(GAP_DELAY - 1);

    // Next-state logic. START, BITS and STOP are all paced in quarter-bit
    // steps: cnt counts clocks within a quarter, qtr counts quarters.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        qtr_n   = qtr;
        bit_n   = bit_idx;
        idx_n   = idx;
        case (state)
            WAIT_INIT: begin
                if (cnt == CW'(INIT_DELAY - 1)) begin
                    state_n = START;
                    cnt_n   = '0;
                    qtr_n   = 2'd0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            START, BITS, STOP: begin
                if (!qtr_last) begin
                    cnt_n = cnt + CW'(1);
                end else begin
                    cnt_n = '0;
                    qtr_n = qtr + 2'd1;
                    if (state == START && qtr == 2'd1) begin
                        state_n = BITS;
                        qtr_n   = 2'd0;
                        bit_n   = 5'd0;
                    end else if (state == BITS && qtr == 2'd3) begin
                        if (bit_idx == 5'd26) begin
                            state_n = STOP;
                            qtr_n   = 2'd0;
                        end else begin
                            bit_n = bit_idx + 5'd1;
                        end
                    end else if (state == STOP && qtr == 2'd1) begin
                        state_n = DELAY;
                        qtr_n   = 2'd0;
                    end
                end
            end
            DELAY: begin
                if (cnt == delay_last) begin
                    cnt_n = '0;
                    if (idx == 5'd16) begin
                        state_n = DONE;
                    end else begin
                        idx_n   = idx + 5'd1;
                        state_n = START;
                        qtr_n   = 2'd0;
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            DONE: begin
                state_n = DONE;
            end
            default: begin
                state_n = WAIT_INIT;
                cnt_n   = '0;
            end
        endcase
    end

    // Output values are decoded from the next state so they can be registered
    // alongside it. In BITS, siod changes only at quarter 0 (sioc low) and
    // sioc is high during quarters 1 and 2.
    always_comb begin
        sioc_n = 1'b1;
        siod_n = 1'b1;
        done_n = 1'b0;
        case (state_n)
            START: begin
                sioc_n = 1'b1;
                siod_n = 1'b0;
            end
            BITS: begin
                sioc_n = (qtr_n == 2'd1) || (qtr_n == 2'd2);
                siod_n = frame[bit_pos];
            end
            STOP: begin
                sioc_n = (qtr_n == 2'd1);
                siod_n = 1'b0;
            end
            DONE: begin
                done_n = 1'b1;
            end
            default: begin
                sioc_n = 1'b1;
                siod_n = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= WAIT_INIT;
            cnt       <= '0;
            qtr       <= 2'd0;
            bit_idx   <= 5'd0;
            idx       <= 5'd0;
            sioc      <= 1'b1;
            siod      <= 1'b1;
            init_done <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            qtr       <= qtr_n;
            bit_idx   <= bit_n;
            idx       <= idx_n;
            sioc      <= sioc_n;
            siod      <= siod_n;
            init_done <= done_n;
        end
    end

endmodule

// File: tb/tb_ov7670_sccb_init.sv
// ----------------------------------------------------------------------------
// tb_ov7670_sccb_init
//
// Bench for ov7670_sccb_init with shortened delays. A bus monitor decodes
// START/STOP conditions and bits on SIOC rising edges, and compares every
// completed write against a scoreboard queue filled at reset release.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ov7670_sccb_init;

    localparam int INIT_DELAY  = 200;
    localparam int RESET_DELAY = 300;
    localparam int GAP_DELAY   = 50;
    localparam int QTR         = 4;
    localparam int TOTAL       = INIT_DELAY + 17 * 28 * 4 * QTR + RESET_DELAY + 16 * GAP_DELAY;

    logic clk = 1'b0;
    logic rst;
    logic sioc, siod, init_done;

    ov7670_sccb_init #(
        .INIT_DELAY (INIT_DELAY),
        .RESET_DELAY(RESET_DELAY),
        .GAP_DELAY  (GAP_DELAY),
        .QTR        (QTR)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sioc     (sioc),
        .siod     (siod),
        .init_done(init_done)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Expected {device, register, value} for each write, in order.
    logic [23:0] exp_q[$];
    logic [15:0] table_ref [17] = '{
        16'h1280, 16'h1214, 16'h40D0, 16'h8C00, 16'h1101, 16'h0C00,
        16'h3E00, 16'h0400, 16'h3A04, 16'h13E7, 16'h1448, 16'h1716,
        16'h1804, 16'h3224, 16'h1902, 16'h1A7A, 16'h030A
    };

    // Clocks since reset release.
    int cyc = 0;
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Bus monitor state.
    logic        prev_sioc = 1'b1, prev_siod = 1'b1, prev_done = 1'b0;
    logic        in_tx = 1'b0;
    int          bitcnt = 0;
    int          edges = 0;
    int          writes_done = 0;
    int          first_start_cyc = -1;
    int          done_cyc = -1;
    logic [26:0] shreg = '0;
    logic [23:0] last_triple = '0;
    logic [2:0]  last_x = '0;

    always @(negedge clk) begin
        if (rst) begin
            in_tx           = 1'b0;
            bitcnt          = 0;
            edges           = 0;
            writes_done     = 0;
            first_start_cyc = -1;
            done_cyc        = -1;
            exp_q.delete();
        end else begin
            if (!prev_sioc && sioc) begin
                edges++;
                if (in_tx && bitcnt < 27) begin
                    shreg = {shreg[25:0], siod};
                    bitcnt++;
                end
            end
            if (prev_sioc && sioc && (prev_siod !== siod)) begin
                vectors++;
                if (!siod) begin
                    if (in_tx) begin
                        miscompares++;
                        $display("[TB] FAIL start_in_tx: siod fell with sioc high after %0d bits, required idle bus", bitcnt);
                    end
                    if (writes_done == 0 && first_start_cyc < 0) first_start_cyc = cyc;
                    in_tx  = 1'b1;
                    bitcnt = 0;
                end else begin
                    if (!in_tx || bitcnt != 27) begin
                        miscompares++;
                        $display("[TB] FAIL stop_bits: stop after %0d bits (in_tx=%0d), required 27", bitcnt, in_tx);
                    end else begin
                        last_triple = {shreg[26:19], shreg[17:10], shreg[8:1]};
                        last_x      = {shreg[18], shreg[9], shreg[0]};
                        vectors++;
                        if (last_x !== 3'b111) begin
                            miscompares++;
                            $display("[TB] FAIL dont_care_bits: got %b, required 111", last_x);
                        end
                        vectors++;
                        if (exp_q.size() == 0) begin
                            miscompares++;
                            $display("[TB] FAIL unexpected_write: got %h, required no write", last_triple);
                        end else begin
                            logic [23:0] exp_v;
                            exp_v = exp_q.pop_front();
                            if (last_triple !== exp_v) begin
                                miscompares++;
                                $display("[TB] FAIL write_%0d: got %h, required %h", writes_done, last_triple, exp_v);
                            end
                        end
                        writes_done++;
                    end
                    in_tx = 1'b0;
                end
            end
            if (!prev_done && init_done) done_cyc = cyc;
        end
        prev_sioc = sioc;
        prev_siod = siod;
        prev_done = init_done;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push_table();
        for (int i = 0; i < 17; i++) exp_q.push_back({8'h42, table_ref[i]});
    endtask

    // Hold reset, check the idle outputs, release and check the init wait.
    task automatic test_reset();
        int bad;
        rst = 1'b1;
        repeat (20) tick();
        vectors++;
        if ({sioc, siod, init_done} !== 3'b110) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: sioc/siod/done=%b, required 110", {sioc, siod, init_done});
        end
        rst = 1'b0;
        push_table();
        bad = 0;
        for (int i = 1; i < INIT_DELAY; i++) begin
            tick();
            if ({sioc, siod, init_done} !== 3'b110) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("[TB] FAIL init_idle: %0d non-idle clocks, required 0", bad);
        end
        tick();
        vectors++;
        if ({sioc, siod} !== 2'b10) begin
            miscompares++;
            $display("[TB] FAIL first_start: sioc/siod=%b at cycle %0d, required 10", {sioc, siod}, cyc);
        end
    endtask

    task automatic test_first_write();
        for (int i = 0; i < 2000 && writes_done < 1; i++) tick();
        vectors++;
        if (writes_done < 1) begin
            miscompares++;
            $display("[TB] FAIL first_write_timeout: writes=%0d, required 1", writes_done);
        end else begin
            vectors++;
            if (first_start_cyc != INIT_DELAY) begin
                miscompares++;
                $display("[TB] FAIL first_start_cycle: got %0d, required %0d", first_start_cyc, INIT_DELAY);
            end
            vectors++;
            if (last_triple !== 24'h421280) begin
                miscompares++;
                $display("[TB] FAIL first_write_bytes: got %h, required 421280", last_triple);
            end
        end
    endtask

    task automatic test_full_sequence();
        for (int i = 0; i < TOTAL + 2000 && !init_done; i++) tick();
        vectors++;
        if (!init_done) begin
            miscompares++;
            $display("[TB] FAIL done_timeout: init_done=%b, required 1", init_done);
        end
        vectors++;
        if (done_cyc < TOTAL - 2 || done_cyc > TOTAL + 2) begin
            miscompares++;
            $display("[TB] FAIL done_cycle: got %0d, required %0d", done_cyc, TOTAL);
        end
        vectors++;
        if (edges != 476) begin
            miscompares++;
            $display("[TB] FAIL sioc_edges: got %0d, required 476", edges);
        end
        vectors++;
        if (writes_done != 17 || exp_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL write_count: got %0d with %0d pending, required 17 with 0", writes_done, exp_q.size());
        end
    endtask

    task automatic test_done_idle();
        int e0, bad;
        e0  = edges;
        bad = 0;
        repeat (1000) begin
            tick();
            if ({sioc, siod, init_done} !== 3'b111) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("[TB] FAIL done_idle: %0d clocks not 111, required 0", bad);
        end
        vectors++;
        if (edges != e0) begin
            miscompares++;
            $display("[TB] FAIL done_edges: got %0d, required %0d", edges, e0);
        end
    endtask

    // Abort in the middle of entry 5's value byte.
    task automatic test_reset_abort();
        for (int i = 0; i < TOTAL && !(writes_done == 5 && in_tx && bitcnt >= 22); i++) tick();
        vectors++;
        if (!(writes_done == 5 && in_tx && bitcnt >= 22)) begin
            miscompares++;
            $display("[TB] FAIL abort_point_timeout: writes=%0d bits=%0d, required 5 and >=22", writes_done, bitcnt);
        end
        rst = 1'b1;
        tick();
        vectors++;
        if ({sioc, siod, init_done} !== 3'b110) begin
            miscompares++;
            $display("[TB] FAIL abort_outputs: sioc/siod/done=%b, required 110", {sioc, siod, init_done});
        end
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_first_write();
        test_full_sequence();
        test_done_idle();
        test_reset();
        test_reset_abort();
        test_reset();
        test_first_write();
        test_full_sequence();
        test_done_idle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ov7670_sccb_init.md
OV7670_SCCB_INIT -- requirements
Module: ov7670_sccb_init

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 The block SHALL provide these parameters (name, default, meaning):
- INIT_DELAY, 100000, clocks of idle after reset before the first write (1 ms at 100 MHz).
- RESET_DELAY, 100000, clocks of idle after the COM7 soft-reset write.
- GAP_DELAY, 5000, clocks of idle after every other write.
- QTR, 250, clocks per quarter SCCB bit period (100 kHz SIOC at 100 MHz).
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, system clock (100 MHz nominal).
- rst, in, 1, synchronous active-high reset.
- sioc, out, 1, SCCB clock; idles high.
- siod, out, 1, SCCB data, push-pull; idles high.
- init_done, out, 1, high once all writes have completed.

Function
REQ-004 The block SHALL write a fixed 17-entry table of {register, value} pairs, in order, to device write address 0x42. Pairs are hex:
- 12 80, 12 14, 40 D0, 8C 00, 11 01, 0C 00
- 3E 00, 04 00, 3A 04, 13 E7, 14 48, 17 16
- 18 04, 32 24, 19 02, 1A 7A, 03 0A
REQ-005 Each write SHALL be a 3-phase SCCB transaction: START, then 27 bits, then STOP. The 27 bits are 0x42, X, reg, X, value, X, MSB first, where X is the don't-care bit.
REQ-006 START: with sioc=1 and siod=1, siod SHALL drop to 0. After 2*QTR clocks sioc SHALL drop to 0.
REQ-007 Each bit SHALL last 4*QTR clocks:
- Quarter 0: sioc=0; siod takes the bit value at the start of this quarter.
- Quarters 1-2: sioc=1.
- Quarter 3: sioc=0.
- siod SHALL change only while sioc=0.
REQ-008 During the don't-care bit siod SHALL be driven 1. Acknowledge is not sampled.
REQ-009 STOP: siod=0 and sioc=0 for QTR clocks, then sioc=1 for QTR clocks, then siod=1.
REQ-010 FSM states SHALL be WAIT_INIT, START, BITS, STOP, DELAY, DONE. Transitions:
- WAIT_INIT (INIT_DELAY clocks) -> START.
- START -> BITS.
- BITS (27 bits) -> STOP.
- STOP -> DELAY.
- DELAY -> START for the next entry, or -> DONE after entry 16.
REQ-011 After entry 0 the DELAY length SHALL be RESET_DELAY; after every other entry it SHALL be GAP_DELAY.
REQ-012 Transaction length SHALL be 4*QTR*27 + 4*QTR clocks (28000 with defaults). Total time from reset release to init_done SHALL be INIT_DELAY + 17*28000 + RESET_DELAY + 16*GAP_DELAY clocks, ±2 clocks (756000 with defaults).
REQ-013 init_done SHALL rise on the clock DONE is entered. In DONE:
- init_done stays 1 until reset; sioc=1 and siod=1 permanently.
- No further transactions occur.
REQ-014 Counters SHALL be wide enough for max(INIT_DELAY, RESET_DELAY) without wrap. The table index SHALL be 5 bits and SHALL never exceed 16.
REQ-015 Outputs SHALL be registered, so sioc and siod are glitch-free.

Reset
REQ-016 While rst=1: sioc=1, siod=1, init_done=0, state=WAIT_INIT, table index=0, all counters=0.
REQ-017 Asserting rst at any point SHALL abort the sequence within one clock, including mid-bit and in DONE. On release the full sequence SHALL restart from entry 0 with a fresh INIT_DELAY.

Verification
REQ-018 Hold rst=1 for 20 clocks, then release -> sioc=1, siod=1, init_done=0 for INIT_DELAY clocks; first siod fall occurs near cycle 100000.
REQ-019 Decode the first transaction on SIOC rising edges -> bytes 0x42, 0x12, 0x80, with each don't-care bit read as 1.
REQ-020 Run to completion -> init_done rises at 756000±2 clocks after release; 476 SIOC rising edges are counted (28 per write); decoded pairs match REQ-004 in order.
REQ-021 After init_done, wait 1000 clocks -> init_done=1, sioc=1, siod=1, and no SIOC edges occur.
REQ-022 Assert rst in the middle of write 5's data byte -> sioc=1, siod=1, init_done=0 on the next clock; after release the sequence restarts with the 0x12 0x80 write.
REQ-023 Check throughout all runs -> siod never changes while sioc=1, except at START and STOP.
